// File: rtl/lsu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lsu_pkg
// Description : Shared types and constants for the load/store unit memory
//               master (RV32I funct3 codes, FSM states, word geometry).
// Revision    : 1.0 - initial release
// ============================================================================
package lsu_pkg;

  // RV32I load/store size and sign codes (funct3 field)
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } lsu_funct3_e;

  // Store path state machine states
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    MERGE = 1'b1
  } lsu_state_e;

  // Bytes per data-memory word
  localparam int WORD_BYTES = 4;

endpackage : lsu_pkg
`default_nettype wire

// File: rtl/lsu_load_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_load_align
// Description : Combinational load lane extraction. Selects the byte or
//               halfword addressed by addr_lo from a memory word and sign- or
//               zero-extends it according to funct3. Word-sized codes pass
//               the word through unchanged.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  output logic [31:0] rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic        w_signed;

  // Pick the addressed lanes out of the word
  always_comb begin
    w_signed = ~funct3[2];
    w_half   = addr_lo[1] ? word[31:16] : word[15:0];
    case (addr_lo)
      2'b00:   w_byte = word[7:0];
      2'b01:   w_byte = word[15:8];
      2'b10:   w_byte = word[23:16];
      default: w_byte = word[31:24];
    endcase
  end

  // Extend the selected lane to 32 bits; funct3[1] set means a full word
  always_comb begin
    case (funct3[1:0])
      2'b00:   rdata = {{24{w_signed & w_byte[7]}}, w_byte};
      2'b01:   rdata = {{16{w_signed & w_half[15]}}, w_half};
      default: rdata = word;
    endcase
  end

endmodule : lsu_load_align
`default_nettype wire

// File: rtl/lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : lsu_mem_master
// Description : Memory-stage initiator for a word-addressed data memory with
//               combinational read and no byte enables. Loads complete one
//               cycle after accept with lane extraction and extension. Word
//               stores write in the accept cycle. Byte/halfword stores do a
//               read (accept cycle) then a merged write (MERGE cycle), during
//               which req_ready is low.
//               Optional feature macro: LSU_MISALIGN_TRAP_EN - when defined,
//               misaligned halfword/word accesses are dropped and reported
//               through resp_err; otherwise low address bits are ignored.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_a,
  output logic [31:0] mem_wd,
  output logic        mem_we,
  input  logic [31:0] mem_rd
);

  // Only the address bits the memory decodes (word index + byte offset) are
  // kept across the MERGE cycle; higher bits cannot change the target word.
  localparam int c_OFS_BITS = $clog2(WORD_BYTES);
  localparam int c_AW       = $clog2(MEM_WORDS) + c_OFS_BITS;

  localparam logic [0:0] c_ST_IDLE  = IDLE;
  localparam logic [0:0] c_ST_MERGE = MERGE;

  logic [0:0]      r_state;
  logic [31:0]     r_old;
  logic [c_AW-1:0] r_addr;
  logic [15:0]     r_wdata;
  logic            r_half;
  logic            r_resp_valid;
  logic [31:0]     r_resp_rdata;
  logic            r_resp_err;

  logic            w_accept;
  logic            w_is_word;
  logic            w_is_half;
  logic            w_misalign;
  logic            w_word_store;
  logic            w_sub_store;
  logic            w_we_raw;
  logic [31:0]     w_load;
  logic [31:0]     w_merged;
  logic [31:0]     w_merge_a;

  // Accept only while idle and out of reset
  assign req_ready = rst_n & (r_state == c_ST_IDLE);
  assign w_accept  = req_valid & req_ready;

  // Decode the access size and the misalignment condition
  always_comb begin
    w_is_word = req_funct3[1];
    w_is_half = ~req_funct3[1] & req_funct3[0];
`ifdef LSU_MISALIGN_TRAP_EN
    w_misalign = (w_is_half & req_addr[0]) |
                 (w_is_word & (req_addr[1:0] != 2'b00));
`else
    w_misalign = 1'b0;
`endif
    w_word_store = w_accept & req_we & w_is_word & ~w_misalign;
    w_sub_store  = w_accept & req_we & ~w_is_word & ~w_misalign;
  end

  // Lane extraction of the word being read in the accept cycle
  lsu_load_align u_load_align (
    .word    (mem_rd),
    .addr_lo (req_addr[1:0]),
    .funct3  (req_funct3),
    .rdata   (w_load)
  );

  // Build the merged word: captured old word with the store lane replaced
  always_comb begin
    w_merged = r_old;
    if (r_half) begin
      if (r_addr[1]) w_merged[31:16] = r_wdata;
      else           w_merged[15:0]  = r_wdata;
    end else begin
      case (r_addr[1:0])
        2'b00:   w_merged[7:0]   = r_wdata[7:0];
        2'b01:   w_merged[15:8]  = r_wdata[7:0];
        2'b10:   w_merged[23:16] = r_wdata[7:0];
        default: w_merged[31:24] = r_wdata[7:0];
      endcase
    end
    w_merge_a                 = '0;
    w_merge_a[c_AW-1:c_OFS_BITS] = r_addr[c_AW-1:c_OFS_BITS];
  end

  // Drive the memory port from the request in IDLE, from captured state in MERGE
  always_comb begin
    mem_a    = {req_addr[31:2], 2'b00};
    mem_wd   = req_wdata;
    w_we_raw = w_word_store;
    if (r_state == c_ST_MERGE) begin
      mem_a    = w_merge_a;
      mem_wd   = w_merged;
      w_we_raw = 1'b1;
    end
  end

  // Reset kills any write in flight immediately, including a pending MERGE
  assign mem_we = w_we_raw & rst_n;

  // Store path state machine and sub-word store capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_ST_IDLE;
      r_old   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_half  <= 1'b0;
    end else begin
      case (r_state)
        c_ST_IDLE: begin
          if (w_sub_store) begin
            r_state <= c_ST_MERGE;
            r_old   <= mem_rd;
            r_addr  <= req_addr[c_AW-1:0];
            r_wdata <= req_wdata[15:0];
            r_half  <= w_is_half;
          end
        end
        default: r_state <= c_ST_IDLE;
      endcase
    end
  end

  // Response pulse: one cycle after a load/word store/trap, or after MERGE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid <= 1'b0;
      r_resp_rdata <= '0;
      r_resp_err   <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      if (r_state == c_ST_MERGE) begin
        r_resp_valid <= 1'b1;
        r_resp_rdata <= '0;
      end else if (w_accept && !w_sub_store) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= w_misalign;
        r_resp_rdata <= (req_we || w_misalign) ? 32'h0 : w_load;
      end
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_rdata = r_resp_rdata;
  assign resp_err   = r_resp_err;

endmodule : lsu_mem_master
`default_nettype wire

// File: tb/tb_lsu_mem_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_lsu_mem_master
// Description : Directed self-checking bench for lsu_mem_master with a
//               behavioural word-addressed data memory.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lsu_mem_master;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_a;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  logic [31:0] mem [0:255];
  logic        pre_en;
  logic [7:0]  pre_idx;
  logic [31:0] pre_dat;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  lsu_mem_master #(.MEM_WORDS(256)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_a      (mem_a),
    .mem_wd     (mem_wd),
    .mem_we     (mem_we),
    .mem_rd     (mem_rd)
  );

  // Data memory: combinational read, write on the rising edge
  assign mem_rd = mem[mem_a[9:2]];
  always @(posedge clk) begin
    if (mem_we)      mem[mem_a[9:2]] <= mem_wd;
    else if (pre_en) mem[pre_idx]    <= pre_dat;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [31:0] addr, input logic [31:0] dat);
    @(negedge clk);
    pre_en  = 1'b1;
    pre_idx = addr[9:2];
    pre_dat = dat;
    @(posedge clk);
    #1 pre_en = 1'b0;
  endtask

  task automatic drive(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd);
    @(negedge clk);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] exp);
    drive(1'b0, f3, addr, 32'h0);
    #1 chk({tag, "_ready"}, {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk({tag, "_valid"}, {31'b0, resp_valid}, 32'd1);
    chk({tag, "_rdata"}, resp_rdata, exp);
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'b000;
    req_addr   = 32'h0;
    req_wdata  = 32'h0;
    pre_en     = 1'b0;
    pre_idx    = 8'h0;
    pre_dat    = 32'h0;

    // Reset state
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_we",    {31'b0, mem_we},    32'd0);
    chk("rst_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata,          32'd0);
    chk("rst_err",   {31'b0, resp_err},   32'd0);

    preload(32'h10, 32'h8000_80FF);
    preload(32'h30, 32'h1122_3344);
    preload(32'h40, 32'hCAFE_F00D);
    preload(32'h50, 32'h0000_0000);

    @(negedge clk);
    rst_n = 1'b1;
    #1 chk("post_rst_ready", {31'b0, req_ready}, 32'd1);

    // Loads with lane select and extension
    do_load("lb_10",  3'b000, 32'h10, 32'hFFFF_FFFF);
    do_load("lbu_10", 3'b100, 32'h10, 32'h0000_00FF);
    do_load("lh_12",  3'b001, 32'h12, 32'hFFFF_8000);
    do_load("lb_11",  3'b000, 32'h11, 32'hFFFF_FF80);
    do_load("lbu_13", 3'b100, 32'h13, 32'h0000_0080);
    do_load("lhu_10", 3'b101, 32'h10, 32'h0000_80FF);
    do_load("lh_10",  3'b001, 32'h10, 32'hFFFF_80FF);

    // Word store: single-cycle write, no stall
    drive(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF);
    #1;
    chk("sw_we_accept", {31'b0, mem_we},    32'd1);
    chk("sw_wd",        mem_wd,             32'hDEAD_BEEF);
    chk("sw_a",         mem_a,              32'h20);
    chk("sw_ready",     {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    #1;
    chk("sw_resp",       {31'b0, resp_valid}, 32'd1);
    chk("sw_resp_rdata", resp_rdata,          32'd0);
    chk("sw_we_after",   {31'b0, mem_we},     32'd0);
    chk("sw_ready_after", {31'b0, req_ready}, 32'd1);
    chk("sw_mem",        mem[8],              32'hDEAD_BEEF);
    do_load("lw_20", 3'b010, 32'h20, 32'hDEAD_BEEF);

    // SB: read in accept cycle, merged write in MERGE
    drive(1'b1, 3'b000, 32'h31, 32'h0000_00AA);
    #1;
    chk("sb_we_accept", {31'b0, mem_we},    32'd0);
    chk("sb_ready0",    {31'b0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    #1;
    chk("sb_ready_merge", {31'b0, req_ready}, 32'd0);
    chk("sb_we_merge",    {31'b0, mem_we},    32'd1);
    chk("sb_a_merge",     mem_a,              32'h30);
    chk("sb_wd_merge",    mem_wd,             32'h1122_AA44);
    chk("sb_no_resp",     {31'b0, resp_valid}, 32'd0);
    @(posedge clk);
    #1;
    chk("sb_ready_back", {31'b0, req_ready}, 32'd1);
    chk("sb_resp",       {31'b0, resp_valid}, 32'd1);
    chk("sb_mem",        mem[12],             32'h1122_AA44);

    // SH on top of the merged word
    drive(1'b1, 3'b001, 32'h32, 32'h1234_5566);
    @(posedge clk);
    #1 req_valid = 1'b0;
    #1 chk("sh_wd_merge", mem_wd, 32'h5566_AA44);
    @(posedge clk);
    #1;
    chk("sh_resp", {31'b0, resp_valid}, 32'd1);
    chk("sh_mem",  mem[12],             32'h5566_AA44);

    // SB then a held LW to the same word: load sees the merged word
    drive(1'b1, 3'b000, 32'h42, 32'h0000_0012);
    @(posedge clk);
    #1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'h40;
    req_wdata  = 32'h0;
    #1 chk("b2b_ready_merge", {31'b0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    chk("b2b_store_resp", {31'b0, resp_valid}, 32'd1);
    chk("b2b_ready_idle", {31'b0, req_ready},  32'd1);
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("b2b_load_valid", {31'b0, resp_valid}, 32'd1);
    chk("b2b_load_rdata", resp_rdata,          32'hCA12_F00D);

    // Misaligned word load
`ifdef LSU_MISALIGN_TRAP_EN
    drive(1'b0, 3'b010, 32'h22, 32'h0);
    #1 chk("mis_we", {31'b0, mem_we}, 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("mis_valid", {31'b0, resp_valid}, 32'd1);
    chk("mis_err",   {31'b0, resp_err},   32'd1);
    chk("mis_rdata", resp_rdata,          32'd0);
    // Misaligned word store must not write
    drive(1'b1, 3'b010, 32'h22, 32'h0BAD_0BAD);
    #1 chk("mis_sw_we", {31'b0, mem_we}, 32'd0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("mis_sw_err", {31'b0, resp_err}, 32'd1);
    chk("mis_sw_mem", mem[8],            32'hDEAD_BEEF);
`else
    drive(1'b0, 3'b010, 32'h22, 32'h0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("mis_valid", {31'b0, resp_valid}, 32'd1);
    chk("mis_err",   {31'b0, resp_err},   32'd0);
    chk("mis_rdata", resp_rdata,          32'hDEAD_BEEF);
    do_load("lh_odd_13", 3'b001, 32'h13, 32'hFFFF_8000);
`endif

    // Reset during MERGE abandons the write
    drive(1'b1, 3'b000, 32'h50, 32'h0000_0077);
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("rstm_we_merge", {31'b0, mem_we}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rstm_we_drop", {31'b0, mem_we},     32'd0);
    chk("rstm_ready",   {31'b0, req_ready},  32'd0);
    chk("rstm_valid",   {31'b0, resp_valid}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rstm_ready_after", {31'b0, req_ready},  32'd1);
    chk("rstm_mem",         mem[20],             32'd0);
    chk("rstm_no_resp",     {31'b0, resp_valid}, 32'd0);
    @(posedge clk);
    #1 chk("rstm_idle_we", {31'b0, mem_we}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule : tb_lsu_mem_master
`default_nettype wire
